// File: rtl/ram_master_pkg.sv
// Shared types and helpers for the single-port RAM access master.
package ram_master_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ADDR    = 3'd1,
        ST_ACCESS  = 3'd2,
        ST_DOUT    = 3'd3,
        ST_CAPTURE = 3'd4,
        ST_RESP    = 3'd5
    } ram_mst_state_e;

    // Handshake edge to first sampled cycle of rsp_valid.
    function automatic int unsigned rd_latency(input bit ap, input bit dp);
        return 32'd3 + 32'(ap) + 32'(dp);
    endfunction

endpackage

// File: rtl/ram_parity_chk.sv
// Even-parity check of RAM read data against the RAM's own parity bit.
module ram_parity_chk
    import ram_master_pkg::*;
#(
    parameter int MEM_WIDTH     = 16,
    parameter bit PARITY_ENABLE = 1'b1
) (
    input  logic [MEM_WIDTH-1:0] dout,
    input  logic                 parity_out,
    output logic                 perr
);

    assign perr = PARITY_ENABLE & (parity_out ^ (^dout));

endmodule

// File: rtl/ram_access_master.sv
// One-command-at-a-time initiator that sequences the pipelined single-port RAM pins.
// Handshakes: a transfer happens on a rising edge where valid & ready; rsp_valid holds until rsp_ready.
module ram_access_master
    import ram_master_pkg::*;
#(
    parameter int    MEM_WIDTH     = 16,
    parameter int    ADD_SIZE      = 10,
    parameter string ADDR_PIPELINE = "FALSE",
    parameter string DOUT_PIPELINE = "TRUE",
    parameter bit    PARITY_ENABLE = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_wr,
    input  logic [ADD_SIZE-1:0]  req_addr,
    input  logic [MEM_WIDTH-1:0] req_wdata,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [MEM_WIDTH-1:0] rsp_data,
    output logic                 rsp_perr,
    output logic [MEM_WIDTH-1:0] din,
    output logic [ADD_SIZE-1:0]  addr,
    output logic                 addr_en,
    output logic                 dout_en,
    output logic                 wr_en,
    output logic                 rd_en,
    output logic                 blk_select,
    input  logic [MEM_WIDTH-1:0] dout,
    input  logic                 parity_out
);

    localparam bit AP = (ADDR_PIPELINE == "TRUE");
    localparam bit DP = (DOUT_PIPELINE == "TRUE");

    localparam logic [2:0] S_IDLE    = 3'(ST_IDLE);
    localparam logic [2:0] S_ADDR    = 3'(ST_ADDR);
    localparam logic [2:0] S_ACCESS  = 3'(ST_ACCESS);
    localparam logic [2:0] S_DOUT    = 3'(ST_DOUT);
    localparam logic [2:0] S_CAPTURE = 3'(ST_CAPTURE);
    localparam logic [2:0] S_RESP    = 3'(ST_RESP);

    logic [2:0]           state;
    logic [2:0]           state_nxt;
    logic                 rdy_en;
    logic                 cmd_wr;
    logic [ADD_SIZE-1:0]  cmd_addr;
    logic [MEM_WIDTH-1:0] cmd_wdata;
    logic                 perr;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (req_valid && req_ready) state_nxt = AP ? S_ADDR : S_ACCESS;
            S_ADDR:    state_nxt = S_ACCESS;
            S_ACCESS:  state_nxt = cmd_wr ? S_IDLE : (DP ? S_DOUT : S_CAPTURE);
            S_DOUT:    state_nxt = S_CAPTURE;
            S_CAPTURE: state_nxt = S_RESP;
            S_RESP:    if (rsp_ready) state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    // rdy_en keeps req_ready low until the first edge after reset release.
    assign req_ready  = (state == S_IDLE) && rdy_en;
    assign rsp_valid  = (state == S_RESP);
    assign blk_select = (state == S_ADDR) || (state == S_ACCESS) ||
                        (state == S_DOUT) || (state == S_CAPTURE);
    assign addr_en    = (state == S_ADDR) || ((state == S_ACCESS) && !AP);
    assign wr_en      = (state == S_ACCESS) && cmd_wr;
    assign rd_en      = (state == S_ACCESS) && !cmd_wr;
    assign dout_en    = (state == S_DOUT);
    assign addr       = cmd_addr;
    assign din        = cmd_wdata;

    ram_parity_chk #(
        .MEM_WIDTH     (MEM_WIDTH),
        .PARITY_ENABLE (PARITY_ENABLE)
    ) u_parity_chk (
        .dout       (dout),
        .parity_out (parity_out),
        .perr       (perr)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            rdy_en    <= 1'b0;
            cmd_wr    <= 1'b0;
            cmd_addr  <= '0;
            cmd_wdata <= '0;
            rsp_data  <= '0;
            rsp_perr  <= 1'b0;
        end else begin
            state  <= state_nxt;
            rdy_en <= 1'b1;
            if (req_valid && req_ready) begin
                cmd_wr    <= req_wr;
                cmd_addr  <= req_addr;
                cmd_wdata <= req_wdata;
            end
            if (state == S_CAPTURE) begin
                rsp_data <= dout;
                rsp_perr <= perr;
            end
        end
    end

endmodule

// File: tb/tb_ram_access_master.sv
// Bench for ram_access_master: four pipeline/parity configurations driven in lockstep, each with a RAM model.
`timescale 1ns/1ps
module tb_ram_access_master;
    import ram_master_pkg::*;

    localparam int W = 16;
    localparam int A = 10;
    localparam int N = 4;
    localparam string S_TRUE  = "TRUE";
    localparam string S_FALSE = "FALSE";

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req_valid = 1'b0;
    logic         req_wr = 1'b0;
    logic [A-1:0] req_addr = '0;
    logic [W-1:0] req_wdata = '0;
    logic         rsp_ready = 1'b1;
    logic         flip_par = 1'b0;

    logic         req_ready [N];
    logic         rsp_valid [N];
    logic         rsp_perr [N];
    logic         addr_en [N];
    logic         dout_en [N];
    logic         wr_en [N];
    logic         rd_en [N];
    logic         blk_select [N];
    logic         parity_out [N];
    logic [W-1:0] rsp_data [N];
    logic [W-1:0] din [N];
    logic [W-1:0] dout [N];
    logic [A-1:0] addr [N];

    int vectors = 0;
    int miscompares = 0;
    logic [W-1:0] ref_mem [2**A];

    always #5 clk = ~clk;

    // Instance 0 is the default configuration; 1..3 cover the other pipeline/parity settings.
    function automatic bit cfg_ap(input int i);
        return i >= 2;
    endfunction
    function automatic bit cfg_dp(input int i);
        return (i == 0) || (i == 3);
    endfunction
    function automatic bit cfg_pe(input int i);
        return i != 3;
    endfunction

    for (genvar gi = 0; gi < N; gi++) begin : g_inst
        localparam bit AP_I = (gi >= 2);
        localparam bit DP_I = (gi == 0) || (gi == 3);
        localparam bit PE_I = (gi != 3);
        logic [W-1:0] mem [2**A];
        logic [A-1:0] addr_q = '0;
        logic [W-1:0] rd_q = '0;
        logic [W-1:0] dout_q = '0;

        initial begin
            for (int k = 0; k < 2**A; k++) mem[k] = W'(k * 37) ^ 16'h5A5A;
        end

        always @(posedge clk) begin
            if (blk_select[gi]) begin
                if (addr_en[gi]) addr_q <= addr[gi];
                if (wr_en[gi]) mem[AP_I ? addr_q : addr[gi]] <= din[gi];
                if (rd_en[gi]) rd_q <= mem[AP_I ? addr_q : addr[gi]];
                if (dout_en[gi]) dout_q <= rd_q;
            end
        end
        assign dout[gi]       = DP_I ? dout_q : rd_q;
        assign parity_out[gi] = (^dout[gi]) ^ flip_par;

        ram_access_master #(
            .MEM_WIDTH     (W),
            .ADD_SIZE      (A),
            .ADDR_PIPELINE (AP_I ? S_TRUE : S_FALSE),
            .DOUT_PIPELINE (DP_I ? S_TRUE : S_FALSE),
            .PARITY_ENABLE (PE_I)
        ) u_dut (
            .clk (clk), .rst (rst),
            .req_valid (req_valid), .req_ready (req_ready[gi]), .req_wr (req_wr),
            .req_addr (req_addr), .req_wdata (req_wdata),
            .rsp_valid (rsp_valid[gi]), .rsp_ready (rsp_ready),
            .rsp_data (rsp_data[gi]), .rsp_perr (rsp_perr[gi]),
            .din (din[gi]), .addr (addr[gi]),
            .addr_en (addr_en[gi]), .dout_en (dout_en[gi]), .wr_en (wr_en[gi]),
            .rd_en (rd_en[gi]), .blk_select (blk_select[gi]),
            .dout (dout[gi]), .parity_out (parity_out[gi])
        );
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_all_ready();
        bit ok = 1'b0;
        for (int t = 0; t < 20 && !ok; t++) begin
            ok = 1'b1;
            for (int i = 0; i < N; i++) if (req_ready[i] !== 1'b1) ok = 1'b0;
            if (!ok) @(negedge clk);
        end
        if (!ok) check("ready_timeout", 32'(ok), 32'd1);
    endtask

    task automatic check_reset_pins(input string tag);
        for (int i = 0; i < N; i++) begin
            check($sformatf("%s_ctrl[%0d]", tag, i),
                  32'({blk_select[i], addr_en[i], wr_en[i], rd_en[i], dout_en[i],
                       rsp_valid[i], req_ready[i], rsp_perr[i]}), 32'd0);
            check($sformatf("%s_addr[%0d]", tag, i), 32'(addr[i]), 32'd0);
            check($sformatf("%s_din[%0d]", tag, i), 32'(din[i]), 32'd0);
            check($sformatf("%s_rdata[%0d]", tag, i), 32'(rsp_data[i]), 32'd0);
        end
    endtask

    // Issues one command to all instances and checks pin timing and result against the model.
    task automatic run_cmd(input bit wr, input logic [A-1:0] a, input logic [W-1:0] d);
        int wr_cnt [N], wr_first [N], rd_first [N], ae_first [N], de_cnt [N], rsp_first [N], rdy_back [N];
        logic [W-1:0] rdat [N];
        logic rperr [N];
        bit both = 1'b0;
        bit done = 1'b0;
        int n = 1;
        for (int i = 0; i < N; i++) begin
            wr_cnt[i] = 0; wr_first[i] = -1; rd_first[i] = -1; ae_first[i] = -1;
            de_cnt[i] = 0; rsp_first[i] = -1; rdy_back[i] = -1; rdat[i] = '0; rperr[i] = 1'b0;
        end
        wait_all_ready();
        req_valid = 1'b1; req_wr = wr; req_addr = a; req_wdata = d;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        while (!done && n <= 12) begin
            for (int i = 0; i < N; i++) begin
                if (wr_en[i] && rd_en[i]) both = 1'b1;
                if (wr_en[i]) begin
                    wr_cnt[i]++;
                    if (wr_first[i] < 0) begin
                        wr_first[i] = n;
                        check($sformatf("wr_blk[%0d]", i), 32'(blk_select[i]), 32'd1);
                        check($sformatf("wr_addr[%0d]", i), 32'(addr[i]), 32'(a));
                        check($sformatf("wr_din[%0d]", i), 32'(din[i]), 32'(d));
                    end
                end
                if (rd_en[i] && rd_first[i] < 0) rd_first[i] = n;
                if (addr_en[i] && ae_first[i] < 0) ae_first[i] = n;
                if (dout_en[i]) de_cnt[i]++;
                if (rsp_valid[i] && rsp_first[i] < 0) begin
                    rsp_first[i] = n; rdat[i] = rsp_data[i]; rperr[i] = rsp_perr[i];
                end
                if (req_ready[i] && rdy_back[i] < 0) rdy_back[i] = n;
            end
            done = 1'b1;
            for (int i = 0; i < N; i++) if (rdy_back[i] < 0) done = 1'b0;
            if (!done) begin
                @(negedge clk);
                n++;
            end
        end
        check("cmd_done", 32'(done), 32'd1);
        check("wr_rd_overlap", 32'(both), 32'd0);
        for (int i = 0; i < N; i++) begin
            int unsigned lat = rd_latency(cfg_ap(i), cfg_dp(i));
            if (wr) begin
                check($sformatf("wr_cnt[%0d]", i), 32'(wr_cnt[i]), 32'd1);
                check($sformatf("wr_lat[%0d]", i), 32'(wr_first[i]), 32'd1 + 32'(cfg_ap(i)));
                check($sformatf("wr_ready[%0d]", i), 32'(rdy_back[i]), 32'd2 + 32'(cfg_ap(i)));
                check($sformatf("wr_no_rsp[%0d]", i), 32'(rsp_first[i]), 32'hFFFF_FFFF);
            end else begin
                check($sformatf("rd_lat[%0d]", i), 32'(rsp_first[i]), lat);
                check($sformatf("rd_data[%0d]", i), 32'(rdat[i]), 32'(ref_mem[a]));
                check($sformatf("rd_perr[%0d]", i), 32'(rperr[i]), 32'(flip_par & cfg_pe(i)));
                check($sformatf("rd_dout_en[%0d]", i), 32'(de_cnt[i]), 32'(cfg_dp(i)));
                check($sformatf("rd_addr_en[%0d]", i), 32'(ae_first[i]), 32'(rd_first[i] - int'(cfg_ap(i))));
                check($sformatf("rd_ready[%0d]", i), 32'(rdy_back[i]), lat + 32'd1);
            end
        end
        if (wr) ref_mem[a] = d;
    endtask

    task automatic bp_read(input logic [A-1:0] a);
        bit ok [N];
        for (int i = 0; i < N; i++) ok[i] = 1'b1;
        wait_all_ready();
        req_valid = 1'b1; req_wr = 1'b0; req_addr = a; req_wdata = $urandom;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        for (int n = 1; n <= 15; n++) begin
            for (int i = 0; i < N; i++) begin
                int lat = int'(rd_latency(cfg_ap(i), cfg_dp(i)));
                if (rsp_valid[i] !== (n >= lat)) ok[i] = 1'b0;
                if (req_ready[i] !== 1'b0) ok[i] = 1'b0;
                if (n >= lat && rsp_data[i] !== ref_mem[a]) ok[i] = 1'b0;
            end
            if (n < 15) @(negedge clk);
        end
        for (int i = 0; i < N; i++) check($sformatf("bp_hold[%0d]", i), 32'(ok[i]), 32'd1);
        rsp_ready = 1'b1;
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            check($sformatf("bp_release_valid[%0d]", i), 32'(rsp_valid[i]), 32'd0);
            check($sformatf("bp_release_ready[%0d]", i), 32'(req_ready[i]), 32'd1);
        end
    endtask

    task automatic reset_mid_read(input logic [A-1:0] a);
        bit seen = 1'b0;
        wait_all_ready();
        req_valid = 1'b1; req_wr = 1'b0; req_addr = a; req_wdata = '0;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check("mid_in_access", 32'(rd_en[0]), 32'd1);
        rst = 1'b1;
        #1;
        check_reset_pins("mid_rst");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < N; i++) check($sformatf("post_rst_ready[%0d]", i), 32'(req_ready[i]), 32'd1);
        for (int n = 0; n < 8; n++) begin
            for (int i = 0; i < N; i++) if (rsp_valid[i]) seen = 1'b1;
            @(negedge clk);
        end
        check("post_rst_no_rsp", 32'(seen), 32'd0);
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [A-1:0] bb_addr [10];
        for (int k = 0; k < 2**A; k++) ref_mem[k] = W'(k * 37) ^ 16'h5A5A;

        @(negedge clk);
        @(negedge clk);
        check_reset_pins("reset");
        rst = 1'b0;
        #1;
        for (int i = 0; i < N; i++) check($sformatf("ready_at_release[%0d]", i), 32'(req_ready[i]), 32'd0);
        @(negedge clk);
        for (int i = 0; i < N; i++) check($sformatf("ready_after_edge[%0d]", i), 32'(req_ready[i]), 32'd1);

        run_cmd(1'b1, 10'h05A, 16'hBEEF);
        run_cmd(1'b0, 10'h05A, 16'h0000);
        run_cmd(1'b0, 10'h123, 16'h0000);

        run_cmd(1'b1, 10'h010, 16'h0001);
        flip_par = 1'b1;
        run_cmd(1'b0, 10'h010, 16'h0000);
        flip_par = 1'b0;

        bp_read(10'h05A);

        for (int i = 0; i < 10; i++) begin
            bb_addr[i] = A'($urandom_range(0, 511));
            run_cmd(1'b1, bb_addr[i], W'(i));
        end
        for (int i = 0; i < 10; i++) run_cmd(1'b0, bb_addr[i], 16'h0000);

        run_cmd(1'b1, 10'h3FF, 16'hFFFF);
        run_cmd(1'b0, 10'h3FF, 16'h0000);

        for (int i = 0; i < 40; i++) begin
            run_cmd(1'($urandom_range(0, 1)), A'($urandom_range(0, 2**A - 1)), W'($urandom));
        end

        reset_mid_read(10'h05A);
        run_cmd(1'b0, 10'h05A, 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
